// File: rtl/fp_vector_engine.sv
// Avalon-MM vector front end for a shared custom-instruction FPU: operand banks A/B,
// result bank R, CTRL/STATUS registers and a start/done sequencer with timeout.
module fp_vector_engine #(
    parameter int DEPTH   = 8,
    parameter int ADDR_W  = $clog2(DEPTH) + 2,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] slaveaddress,
    input  logic              slaveread,
    input  logic              slavewrite,
    input  logic [31:0]       slavewritedata,
    output logic [31:0]       slavereaddata,
    output logic              slavereaddatavalid,
    output logic              slavewaitrequest,
    output logic              fpu_clk_en,
    output logic              fpu_start,
    output logic [7:0]        fpu_n,
    output logic [31:0]       fpu_dataa,
    output logic [31:0]       fpu_datab,
    input  logic              fpu_done,
    input  logic [31:0]       fpu_result
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
    state_t state, state_next;

    logic [31:0] a_mem [DEPTH];
    logic [31:0] b_mem [DEPTH];
    logic [31:0] r_mem [DEPTH];

    logic [7:0]       ctrl_opcode;
    logic [15:0]      ctrl_count;
    logic [CNT_W-1:0] run_count, idx, next_idx, done_cnt;
    logic [TMR_W-1:0] timer;
    logic             done_flag, err_flag, tmo_flag;

    logic [1:0]       region;
    logic [IDX_W-1:0] widx;
    logic [15:0]      wr_count;
    logic             busy, ctrl_wr, start_req, clear_req, start_ok;
    logic             bank_wr, a_wr_ok, b_wr_ok;
    logic             last_elem, tmo_hit, elem_done, advance, rd_ok;
    logic [31:0]      rd_mux;
    logic             unused_wdata;

    assign region    = slaveaddress[ADDR_W-1:ADDR_W-2];
    assign widx      = slaveaddress[IDX_W-1:0];
    assign wr_count  = slavewritedata[31:16];
    assign busy      = (state != IDLE);
    assign ctrl_wr   = slavewrite && (region == 2'b00) && (widx == '0);
    assign start_req = ctrl_wr && slavewritedata[0];
    assign clear_req = ctrl_wr && slavewritedata[1];
    assign start_ok  = start_req && !busy && (wr_count != 16'd0) && (wr_count <= 16'(DEPTH));
    assign bank_wr   = slavewrite && ((region == 2'b01) || (region == 2'b10));
    assign a_wr_ok   = slavewrite && (region == 2'b01) && !busy;
    assign b_wr_ok   = slavewrite && (region == 2'b10) && !busy;
    assign unused_wdata = ^slavewritedata[7:2];

    assign next_idx  = idx + CNT_W'(1);
    assign last_elem = (next_idx == run_count);
    assign tmo_hit   = (timer == TMR_W'(TIMEOUT - 1));
    assign elem_done = (state == WAIT) && fpu_done;
    assign advance   = elem_done && !last_elem;

    // R reads stall until the addressed element has been produced by the current run
    assign slavewaitrequest = slaveread && !slavewrite && busy && (region == 2'b11)
                              && ({1'b0, widx} >= done_cnt);
    assign rd_ok = slaveread && !slavewrite && !slavewaitrequest;

    always_comb begin
        rd_mux = '0;
        case (region)
            2'b00: begin
                if (widx == IDX_W'(0))
                    rd_mux = {ctrl_count, ctrl_opcode, 8'h00};
                else if (widx == IDX_W'(1))
                    rd_mux = {16'(done_cnt), 12'h000, tmo_flag, err_flag, done_flag, busy};
            end
            2'b01:   rd_mux = a_mem[widx];
            2'b10:   rd_mux = b_mem[widx];
            default: rd_mux = r_mem[widx];
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        fpu_start  = 1'b0;
        fpu_clk_en = 1'b0;
        case (state)
            IDLE: if (start_ok) state_next = ISSUE;
            ISSUE: begin
                fpu_start  = 1'b1;
                fpu_clk_en = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                fpu_clk_en = 1'b1;
                if (fpu_done)     state_next = last_elem ? IDLE : ISSUE;
                else if (tmo_hit) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Control and status; later statements win, so CLEAR lands before START and run events
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_opcode        <= '0;
            ctrl_count         <= '0;
            run_count          <= '0;
            idx                <= '0;
            done_cnt           <= '0;
            timer              <= '0;
            done_flag          <= 1'b0;
            err_flag           <= 1'b0;
            tmo_flag           <= 1'b0;
            fpu_n              <= '0;
            slavereaddata      <= '0;
            slavereaddatavalid <= 1'b0;
        end else begin
            slavereaddatavalid <= rd_ok;
            if (rd_ok) slavereaddata <= rd_mux;
            if (ctrl_wr) begin
                ctrl_opcode <= slavewritedata[15:8];
                ctrl_count  <= wr_count;
            end
            if (clear_req) begin
                done_flag <= 1'b0;
                err_flag  <= 1'b0;
                tmo_flag  <= 1'b0;
            end
            if (start_req) begin
                if (busy || (wr_count > 16'(DEPTH))) begin
                    err_flag <= 1'b1;
                end else if (wr_count == 16'd0) begin
                    done_flag <= 1'b1;
                    done_cnt  <= '0;
                end else begin
                    idx       <= '0;
                    done_cnt  <= '0;
                    done_flag <= 1'b0;
                    run_count <= wr_count[CNT_W-1:0];
                    fpu_n     <= slavewritedata[15:8];
                end
            end
            if (bank_wr && busy) err_flag <= 1'b1;
            if (state == ISSUE) timer <= '0;
            if (state == WAIT) begin
                if (fpu_done) begin
                    done_cnt <= next_idx;
                    if (last_elem) done_flag <= 1'b1;
                    else           idx       <= next_idx;
                end else if (tmo_hit) begin
                    err_flag <= 1'b1;
                    tmo_flag <= 1'b1;
                end else begin
                    timer <= timer + TMR_W'(1);
                end
            end
        end
    end

    // Banks and operand registers carry no reset; a done arriving during reset is dropped
    always_ff @(posedge clk) begin
        if (a_wr_ok) a_mem[widx] <= slavewritedata;
        if (b_wr_ok) b_mem[widx] <= slavewritedata;
        if (elem_done && !reset) r_mem[idx[IDX_W-1:0]] <= fpu_result;
        if (start_ok) begin
            fpu_dataa <= a_mem[0];
            fpu_datab <= b_mem[0];
        end else if (advance) begin
            fpu_dataa <= a_mem[next_idx[IDX_W-1:0]];
            fpu_datab <= b_mem[next_idx[IDX_W-1:0]];
        end
    end

endmodule

// File: tb/tb_fp_vector_engine.sv
// Directed bench for fp_vector_engine: FPU stub with fixed latency, read scoreboard,
// immediate-assertion checks on status, timing, stalls, errors, timeout and reset.
module tb_fp_vector_engine;

    localparam int DEPTH  = 8;
    localparam int ADDR_W = 5;
    localparam int TMO    = 16;
    localparam int LAT    = 3;
    localparam logic [31:0] ONE   = 32'h3F800000;
    localparam logic [31:0] TWO   = 32'h40000000;
    localparam logic [31:0] THREE = 32'h40400000;

    logic              clk = 1'b0;
    logic              reset;
    logic [ADDR_W-1:0] slaveaddress;
    logic              slaveread, slavewrite;
    logic [31:0]       slavewritedata, slavereaddata;
    logic              slavereaddatavalid, slavewaitrequest;
    logic              fpu_clk_en, fpu_start;
    logic [7:0]        fpu_n;
    logic [31:0]       fpu_dataa, fpu_datab;
    logic              fpu_done = 1'b0;
    logic [31:0]       fpu_result = '0;

    fp_vector_engine #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset),
        .slaveaddress(slaveaddress), .slaveread(slaveread), .slavewrite(slavewrite),
        .slavewritedata(slavewritedata), .slavereaddata(slavereaddata),
        .slavereaddatavalid(slavereaddatavalid), .slavewaitrequest(slavewaitrequest),
        .fpu_clk_en(fpu_clk_en), .fpu_start(fpu_start), .fpu_n(fpu_n),
        .fpu_dataa(fpu_dataa), .fpu_datab(fpu_datab),
        .fpu_done(fpu_done), .fpu_result(fpu_result)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass = 0;
    int n_starts = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];
    bit          fpu_hang = 1'b0;
    int          pend = 0;
    logic [31:0] cap_a, cap_b;
    logic [7:0]  cap_n;
    logic [31:0] va [DEPTH];
    logic [31:0] vb [DEPTH];

    function automatic void chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endfunction

    // Stand-in FPU: exact add for the 1.0/2.0 pair, a synthetic opcode-tagged XOR otherwise
    function automatic logic [31:0] fpu_model(input logic [7:0] n, input logic [31:0] a, input logic [31:0] b);
        if (n == 8'd253) begin
            if ((a == ONE && b == TWO) || (a == TWO && b == ONE)) return THREE;
            return 32'h7FC00000;
        end
        return a ^ b ^ {n, 24'h000000};
    endfunction

    always @(negedge clk) begin
        fpu_done = 1'b0;
        if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                fpu_done   = 1'b1;
                fpu_result = fpu_model(cap_n, cap_a, cap_b);
            end
        end
        if (fpu_start) begin
            n_starts++;
            if (!fpu_hang) begin
                pend  = LAT;
                cap_a = fpu_dataa;
                cap_b = fpu_datab;
                cap_n = fpu_n;
            end
        end
    end

    always @(negedge clk) begin
        if (slavereaddatavalid) begin
            if (exp_q.size() == 0) chk("unexpected_rdvalid", 32'd1, 32'd0);
            else                   chk(tag_q.pop_front(), slavereaddata, exp_q.pop_front());
        end
    end

    function automatic logic [ADDR_W-1:0] ad(input logic [1:0] r, input int i);
        return {r, 3'(i)};
    endfunction

    function automatic logic [31:0] cw(input int count, input logic [7:0] op, input bit clr, input bit st);
        return {16'(count), op, 6'b000000, clr, st};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [ADDR_W-1:0] a, input logic [31:0] d);
        slavewrite = 1'b1; slaveaddress = a; slavewritedata = d;
        tick();
        slavewrite = 1'b0;
    endtask

    task automatic bus_read(input logic [ADDR_W-1:0] a, input logic [31:0] exp,
                            input string tag, output int stalls);
        slaveread = 1'b1; slaveaddress = a;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        stalls = 0;
        @(negedge clk);
        while (slavewaitrequest && stalls < 200) begin
            stalls++;
            @(negedge clk);
        end
        if (stalls >= 200) chk({tag, "_stall_bound"}, 32'(stalls), 32'd0);
        tick();
        slaveread = 1'b0;
    endtask

    task automatic rd(input logic [ADDR_W-1:0] a, input logic [31:0] exp, input string tag);
        int st;
        bus_read(a, exp, tag, st);
    endtask

    task automatic wait_idle(output int busy_cycles);
        busy_cycles = 0;
        @(negedge clk);
        while (fpu_clk_en && busy_cycles < 1000) begin
            busy_cycles++;
            @(negedge clk);
        end
        if (busy_cycles >= 1000) chk("idle_bound", 32'(busy_cycles), 32'd0);
        tick();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int bc, st, s0;
        logic [ADDR_W-1:0] CTRL, STAT;
        CTRL = ad(2'b00, 0);
        STAT = ad(2'b00, 1);
        reset = 1'b1; slaveread = 1'b0; slavewrite = 1'b0;
        slaveaddress = '0; slavewritedata = '0;
        tick(); tick();
        reset = 1'b0;

        chk("rst_rdvalid", 32'(slavereaddatavalid), 32'd0);
        chk("rst_fpu_start", 32'(fpu_start), 32'd0);
        chk("rst_fpu_clk_en", 32'(fpu_clk_en), 32'd0);
        chk("rst_fpu_n", 32'(fpu_n), 32'd0);
        rd(STAT, 32'h0, "rst_status");
        rd(CTRL, 32'h0, "rst_ctrl");

        // add vector, STATUS sampled every cycle of the run
        bus_write(ad(2'b01, 0), ONE);
        bus_write(ad(2'b01, 1), TWO);
        bus_write(ad(2'b10, 0), TWO);
        bus_write(ad(2'b10, 1), ONE);
        rd(ad(2'b01, 1), TWO, "a1_readback");
        bus_write(CTRL, cw(2, 8'd253, 1'b0, 1'b1));
        for (int c = 1; c <= 10; c++)
            rd(STAT, (c <= 4) ? 32'h00000001 : (c <= 8) ? 32'h00010001 : 32'h00020002,
               $sformatf("run1_status_c%0d", c));
        rd(ad(2'b11, 0), THREE, "run1_r0");
        rd(ad(2'b11, 1), THREE, "run1_r1");
        rd(CTRL, 32'h0002FD00, "run1_ctrl");

        // stalled R[1] read issued in cycle 2
        bus_write(CTRL, cw(2, 8'd1, 1'b1, 1'b1));
        tick();
        bus_read(ad(2'b11, 1), fpu_model(8'd1, TWO, ONE), "stall_r1", st);
        chk("stall_r1_cycles", 32'(st), 32'd7);
        bus_read(ad(2'b11, 0), fpu_model(8'd1, ONE, TWO), "nostall_r0", st);
        chk("nostall_r0_cycles", 32'(st), 32'd0);
        rd(STAT, 32'h00020002, "run2_status");

        // error cases
        bus_write(CTRL, cw(0, 8'd0, 1'b1, 1'b0));
        s0 = n_starts;
        bus_write(CTRL, cw(DEPTH + 1, 8'd253, 1'b0, 1'b1));
        rd(STAT, 32'h00020004, "over_status");
        chk("over_no_start", 32'(n_starts), 32'(s0));
        bus_write(CTRL, cw(0, 8'd0, 1'b1, 1'b0));
        bus_write(CTRL, cw(2, 8'd253, 1'b0, 1'b1));
        bus_write(CTRL, cw(1, 8'd1, 1'b0, 1'b1));
        bus_write(ad(2'b01, 0), 32'hDEADBEEF);
        wait_idle(bc);
        chk("busy_run_cycles", 32'(bc), 32'd6);
        rd(STAT, 32'h00020006, "busy_err_status");
        rd(ad(2'b11, 0), THREE, "busy_run_r0");
        rd(ad(2'b11, 1), THREE, "busy_run_r1");
        rd(ad(2'b01, 0), ONE, "a0_unchanged");
        rd(CTRL, 32'h00010100, "ctrl_last_written");

        // timeout with a silent FPU
        fpu_hang = 1'b1;
        bus_write(CTRL, cw(1, 8'd253, 1'b1, 1'b1));
        wait_idle(bc);
        chk("tmo_busy_cycles", 32'(bc), 32'd17);
        rd(STAT, 32'h0000000C, "tmo_status");
        bus_write(CTRL, cw(0, 8'd0, 1'b1, 1'b0));
        rd(STAT, 32'h00000000, "clear_status");
        fpu_hang = 1'b0;

        // COUNT=0
        s0 = n_starts;
        bus_write(CTRL, cw(0, 8'd253, 1'b0, 1'b1));
        rd(STAT, 32'h00000002, "cnt0_status");
        tick(); tick(); tick();
        chk("cnt0_no_start", 32'(n_starts), 32'(s0));

        // full-depth run
        for (int i = 0; i < DEPTH; i++) begin
            va[i] = $urandom;
            vb[i] = $urandom;
            bus_write(ad(2'b01, i), va[i]);
            bus_write(ad(2'b10, i), vb[i]);
        end
        bus_write(CTRL, cw(DEPTH, 8'd1, 1'b1, 1'b1));
        wait_idle(bc);
        chk("run8a_cycles", 32'(bc), 32'd32);
        rd(STAT, 32'h00080002, "run8a_status");
        for (int i = 0; i < DEPTH; i++)
            rd(ad(2'b11, i), fpu_model(8'd1, va[i], vb[i]), $sformatf("run8a_r%0d", i));

        // reset while element 3 is waiting on the FPU
        bus_write(CTRL, cw(DEPTH, 8'd2, 1'b0, 1'b1));
        repeat (13) tick();
        chk("pre_reset_clk_en", 32'(fpu_clk_en), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("post_reset_clk_en", 32'(fpu_clk_en), 32'd0);
        rd(STAT, 32'h00000000, "post_reset_status");
        rd(CTRL, 32'h00000000, "post_reset_ctrl");
        tick(); tick();
        for (int i = 0; i < DEPTH; i++)
            rd(ad(2'b11, i), fpu_model((i < 3) ? 8'd2 : 8'd1, va[i], vb[i]),
               $sformatf("reset_run_r%0d", i));

        // fresh run after reset
        bus_write(CTRL, cw(DEPTH, 8'd3, 1'b0, 1'b1));
        wait_idle(bc);
        chk("run8b_cycles", 32'(bc), 32'd32);
        rd(STAT, 32'h00080002, "run8b_status");
        for (int i = 0; i < DEPTH; i++)
            rd(ad(2'b11, i), fpu_model(8'd3, va[i], vb[i]), $sformatf("run8b_r%0d", i));

        tick(); tick(); tick();
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
